seq_code_lock: RTL and testbench

Parametrised sequential code lock: successor to the team's fixed two-button, fixed-sequence lock. Accepts encoded key presses from NUM_KEYS buttons, matches them against a CODE_LEN-symbol code supplied on a port, holds `unlock` for a bounded time, and enters a timed lockout after MAX_FAILS consecutive failed attempts. Sits between the debounced button encoder and the actuator/LED driver.

---
 rtl/seq_code_lock_pkg.sv | 31 +++
 rtl/seq_code_lock_if.sv | 30 +++
 rtl/seq_code_lock_timer.sv | 26 ++
 rtl/seq_code_lock.sv | 151 +++++++++++++++
 tb/tb_seq_code_lock.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/seq_code_lock_pkg.sv
// Shared types and width helpers for the sequential code lock.
// Width helpers are constant functions so that both the interface and the RTL agree on port sizes.
package seq_lock_pkg;

   typedef enum logic [1:0] {
      ENTRY   = 2'd0,
      OPEN    = 2'd1,
      LOCKOUT = 2'd2
   } lock_state_e;

   function automatic int unsigned key_w(input int unsigned num_keys);
      return (num_keys <= 2) ? 1 : int'($clog2(num_keys));
   endfunction

   function automatic int unsigned pos_w(input int unsigned code_len);
      return (code_len <= 2) ? 1 : int'($clog2(code_len));
   endfunction

   function automatic int unsigned fail_w(input int unsigned max_fails);
      return int'($clog2(max_fails + 1));
   endfunction

   function automatic int unsigned timer_w(input int unsigned cycles);
      return int'($clog2(cycles + 1));
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/seq_code_lock_if.sv
// Key-entry / status bundle between the button encoder, the lock and the actuator driver.
interface seq_code_lock_if
   import seq_lock_pkg::*;
#(
   parameter int unsigned NUM_KEYS  = 4,
   parameter int unsigned CODE_LEN  = 4,
   parameter int unsigned MAX_FAILS = 3
);
   localparam int unsigned KEY_W  = key_w(NUM_KEYS);
   localparam int unsigned FAIL_W = fail_w(MAX_FAILS);

   logic                      key_vld;
   logic [KEY_W-1:0]          key_id;
   logic [CODE_LEN*KEY_W-1:0] code_i;
   logic                      relock;
   logic                      unlock;
   logic                      led;
   logic                      lockout;
   logic [FAIL_W-1:0]         fail_cnt;

   modport master (
      output key_vld, key_id, code_i, relock,
      input  unlock, led, lockout, fail_cnt
   );

   modport slave (
      input  key_vld, key_id, code_i, relock,
      output unlock, led, lockout, fail_cnt
   );
endinterface

// File: rtl/seq_code_lock_timer.sv
// Loadable down-counter; o_expired flags the last counted cycle so the owner can act on that edge.
module seq_lock_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic [W-1:0] o_value,
   output logic         o_expired
);
   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_value   = r_cnt;
   assign o_expired = (r_cnt == W'(1));
endmodule

// File: rtl/seq_code_lock.sv
// Parametrised sequential code lock with bounded unlock window and timed lockout.
// Optional inter-key timeout enabled by defining SEQ_LOCK_TIMEOUT_EN.
module seq_code_lock
   import seq_lock_pkg::*;
#(
   parameter int unsigned NUM_KEYS       = 4,
   parameter int unsigned CODE_LEN       = 4,
   parameter int unsigned MAX_FAILS      = 3,
   parameter int unsigned UNLOCK_CYCLES  = 16,
   parameter int unsigned LOCKOUT_CYCLES = 32,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input logic            clk,
   input logic            rst_n,
   seq_code_lock_if.slave lk_if
);
   localparam int unsigned KEY_W  = key_w(NUM_KEYS);
   localparam int unsigned POS_W  = pos_w(CODE_LEN);
   localparam int unsigned FAIL_W = fail_w(MAX_FAILS);
   localparam int unsigned TMR_W  = timer_w(max_u(UNLOCK_CYCLES, LOCKOUT_CYCLES));

   localparam logic [POS_W-1:0]  POS_LAST = POS_W'(CODE_LEN - 1);
   localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAILS);

   lock_state_e       r_state, w_state_nxt;
   logic [POS_W-1:0]  r_pos, w_pos_nxt;
   logic [FAIL_W-1:0] r_fail, w_fail_nxt;
   logic              r_unlock, r_led, r_lockout;

   logic [KEY_W-1:0]  w_sym [CODE_LEN];
   logic              w_key_ok, w_match, w_hit0;
   logic              w_tmr_load, w_tmr_expired;
   logic [TMR_W-1:0]  w_tmr_load_val, w_tmr_value_unused;

   // OPEN and LOCKOUT are mutually exclusive, so one counter times both windows.
   seq_lock_timer #(.W(TMR_W)) u_state_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_load_val),
      .o_value    (w_tmr_value_unused),
      .o_expired  (w_tmr_expired)
   );

`ifdef SEQ_LOCK_TIMEOUT_EN
   localparam int unsigned TO_W = timer_w(TIMEOUT_CYCLES);
   logic            w_to_load, w_to_expired;
   logic [TO_W-1:0] w_to_value_unused;

   assign w_to_load = (r_state == ENTRY) && lk_if.key_vld;

   seq_lock_timer #(.W(TO_W)) u_key_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_to_load),
      .i_load_val (TO_W'(TIMEOUT_CYCLES)),
      .o_value    (w_to_value_unused),
      .o_expired  (w_to_expired)
   );
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

   always_comb begin
      for (int unsigned k = 0; k < CODE_LEN; k++) begin
         w_sym[k] = lk_if.code_i[k*KEY_W +: KEY_W];
      end
   end

   // Out-of-range key ids never match, even if the code holds the same value.
   assign w_key_ok = ({1'b0, lk_if.key_id} < (KEY_W+1)'(NUM_KEYS));
   assign w_match  = w_key_ok && (lk_if.key_id == w_sym[r_pos]);
   assign w_hit0   = w_key_ok && (lk_if.key_id == w_sym[0]);

   always_comb begin
      w_state_nxt    = r_state;
      w_pos_nxt      = r_pos;
      w_fail_nxt     = r_fail;
      w_tmr_load     = 1'b0;
      w_tmr_load_val = '0;
      case (r_state)
         ENTRY: begin
            if (lk_if.key_vld) begin
               if (w_match) begin
                  if (r_pos == POS_LAST) begin
                     w_state_nxt    = OPEN;
                     w_pos_nxt      = '0;
                     w_fail_nxt     = '0;
                     w_tmr_load     = 1'b1;
                     w_tmr_load_val = TMR_W'(UNLOCK_CYCLES);
                  end else begin
                     w_pos_nxt = r_pos + POS_W'(1);
                  end
               end else if (r_pos != '0) begin
                  if (r_fail != FAIL_MAX) w_fail_nxt = r_fail + FAIL_W'(1);
                  if (w_fail_nxt == FAIL_MAX) begin
                     w_state_nxt    = LOCKOUT;
                     w_pos_nxt      = '0;
                     w_tmr_load     = 1'b1;
                     w_tmr_load_val = TMR_W'(LOCKOUT_CYCLES);
                  end else begin
                     w_pos_nxt = w_hit0 ? POS_W'(1) : '0;
                  end
               end
            end
`ifdef SEQ_LOCK_TIMEOUT_EN
            else if ((r_pos != '0) && w_to_expired) begin
               w_pos_nxt = '0;
            end
`endif
         end
         OPEN: begin
            if (lk_if.relock || w_tmr_expired) w_state_nxt = ENTRY;
         end
         LOCKOUT: begin
            if (w_tmr_expired) begin
               w_state_nxt = ENTRY;
               w_fail_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt = ENTRY;
            w_pos_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ENTRY;
         r_pos     <= '0;
         r_fail    <= '0;
         r_unlock  <= 1'b0;
         r_led     <= 1'b0;
         r_lockout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pos     <= w_pos_nxt;
         r_fail    <= w_fail_nxt;
         r_unlock  <= (w_state_nxt == OPEN);
         r_led     <= (w_state_nxt == OPEN);
         r_lockout <= (w_state_nxt == LOCKOUT);
      end
   end

   assign lk_if.unlock   = r_unlock;
   assign lk_if.led      = r_led;
   assign lk_if.lockout  = r_lockout;
   assign lk_if.fail_cnt = r_fail;
endmodule

// File: tb/tb_seq_code_lock.sv
// Directed self-checking bench for seq_code_lock with default parameters and code 1-3-0-2.
module tb_seq_code_lock;
   logic clk;
   logic rst_n;
   int   n_err;
   int   n_chk;

   seq_code_lock_if #(.NUM_KEYS(4), .CODE_LEN(4), .MAX_FAILS(3)) bus ();

   seq_code_lock #(
      .NUM_KEYS       (4),
      .CODE_LEN       (4),
      .MAX_FAILS      (3),
      .UNLOCK_CYCLES  (16),
      .LOCKOUT_CYCLES (32),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .lk_if (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic press(input logic [1:0] k);
      bus.key_vld = 1'b1;
      bus.key_id  = k;
      tick();
      bus.key_vld = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic ul, input logic lo, input logic [1:0] fc);
      check({tag, "_unlock"}, 32'(bus.unlock), 32'(ul));
      check({tag, "_led"}, 32'(bus.led), 32'(ul));
      check({tag, "_lockout"}, 32'(bus.lockout), 32'(lo));
      check({tag, "_fail_cnt"}, 32'(bus.fail_cnt), 32'(fc));
   endtask

   initial begin
      n_err       = 0;
      n_chk       = 0;
      rst_n       = 1'b0;
      bus.key_vld = 1'b0;
      bus.key_id  = 2'd0;
      bus.relock  = 1'b0;
      bus.code_i  = {2'd2, 2'd0, 2'd3, 2'd1};
      idle(2);
      check_outs("reset", 1'b0, 1'b0, 2'd0);
      rst_n = 1'b1;
      idle(2);

      // Straight unlock on consecutive cycles, then exactly 16 cycles high.
      press(2'd1); press(2'd3); press(2'd0);
      check_outs("pre_final", 1'b0, 1'b0, 2'd0);
      press(2'd2);
      check_outs("open_e0", 1'b1, 1'b0, 2'd0);
      for (int i = 1; i < 16; i++) begin
         tick();
         check("open_hold", 32'(bus.unlock), 32'd1);
      end
      tick();
      check_outs("open_end", 1'b0, 1'b0, 2'd0);

      // Overlapping restart after a failed third key.
      press(2'd1); press(2'd3); press(2'd1);
      check_outs("overlap_fail", 1'b0, 1'b0, 2'd1);
      press(2'd3); press(2'd0); press(2'd2);
      check_outs("overlap_open", 1'b1, 1'b0, 2'd0);
      bus.relock = 1'b1; tick(); bus.relock = 1'b0;
      check_outs("overlap_relock", 1'b0, 1'b0, 2'd0);

      // Relock on the 5th OPEN cycle; keys during OPEN must not advance entry.
      press(2'd1); press(2'd3); press(2'd0); press(2'd2);
      check("relock_open", 32'(bus.unlock), 32'd1);
      press(2'd1); press(2'd3); press(2'd0);
      tick();
      check("relock_still_open", 32'(bus.unlock), 32'd1);
      bus.relock = 1'b1; tick(); bus.relock = 1'b0;
      check_outs("relock_closed", 1'b0, 1'b0, 2'd0);
      press(2'd2);
      check_outs("relock_ignored_keys", 1'b0, 1'b0, 2'd0);
      press(2'd1); press(2'd3); press(2'd0); press(2'd2);
      check("relock_reentry", 32'(bus.unlock), 32'd1);
      bus.relock = 1'b1; tick(); bus.relock = 1'b0;

      // Three failures trigger a 32-cycle lockout.
      for (int r = 1; r <= 3; r++) begin
         press(2'd1); press(2'd2);
         check("fail_ramp", 32'(bus.fail_cnt), 32'(r));
      end
      check_outs("lockout_l0", 1'b0, 1'b1, 2'd3);
      press(2'd1); press(2'd3); press(2'd0); press(2'd2);
      check_outs("lockout_keys", 1'b0, 1'b1, 2'd3);
      idle(27);
      check_outs("lockout_l31", 1'b0, 1'b1, 2'd3);
      tick();
      check_outs("lockout_done", 1'b0, 1'b0, 2'd0);
      press(2'd1); press(2'd3); press(2'd0); press(2'd2);
      check_outs("post_lockout_open", 1'b1, 1'b0, 2'd0);
      bus.relock = 1'b1; tick(); bus.relock = 1'b0;

      // Asynchronous reset mid-entry with a pending failure.
      press(2'd1); press(2'd2);
      press(2'd1); press(2'd3);
      check("rst_entry_pre", 32'(bus.fail_cnt), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_outs("rst_entry_async", 1'b0, 1'b0, 2'd0);
      tick();
      rst_n = 1'b1;
      press(2'd0); press(2'd2);
      check_outs("rst_entry_after", 1'b0, 1'b0, 2'd0);

      // Asynchronous reset mid-lockout.
      for (int r = 0; r < 3; r++) begin
         press(2'd1); press(2'd2);
      end
      idle(5);
      check_outs("rst_lock_pre", 1'b0, 1'b1, 2'd3);
      #2 rst_n = 1'b0;
      #1 check_outs("rst_lock_async", 1'b0, 1'b0, 2'd0);
      tick();
      rst_n = 1'b1;
      press(2'd0); press(2'd2);
      check_outs("rst_lock_after", 1'b0, 1'b0, 2'd0);

      // Long pause after the first key.
      press(2'd1);
      idle(64);
      press(2'd3); press(2'd0); press(2'd2);
`ifdef SEQ_LOCK_TIMEOUT_EN
      check("timeout_no_open", 32'(bus.unlock), 32'd0);
`else
      check("no_timeout_open", 32'(bus.unlock), 32'd1);
`endif
      bus.relock = 1'b1; tick(); bus.relock = 1'b0;
      check("final_closed", 32'(bus.unlock), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
